// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-add per clock LSB first, carry held in a flop
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_c, w_last, w_load;
  always_comb begin
    w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_last = r_cnt == CW'(WIDTH - 1);
    w_load = start && (r_state != SHIFT);
    w_next = w_load ? SHIFT : (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : IDLE;
  end
  assign busy = r_state == SHIFT;
  assign done = r_state == DONE;
  // The last bit is folded straight into sum so the result appears on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_carry  <= w_c;
        r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          sum  <= {w_s, r_sum_sr[WIDTH-1:1]};
          cout <= w_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against a+b+cin
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, cout;
  logic [7:0] sum;
  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  // Launch one add and return at the negedge where done is first seen.
  task automatic do_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic, output int lat);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 40);
  endtask

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h exp 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat;
    do_add(8'h00, 8'h00, 1'b0, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL zero_latency got %0d exp 9", lat); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL zero_sum got %h exp 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL zero_cout got %b exp 0", cout); end
  endtask

  task automatic test_carry();
    int lat;
    do_add(8'hFF, 8'h01, 1'b0, lat);
    checks++; if (sum !== 8'h00 || cout !== 1'b1) begin errors++; $display("FAIL ripple got %b_%h exp 1_00", cout, sum); end
    do_add(8'hFF, 8'hFF, 1'b1, lat);
    checks++; if (sum !== 8'hFF || cout !== 1'b1) begin errors++; $display("FAIL max_cin got %b_%h exp 1_ff", cout, sum); end
  endtask

  task automatic test_ignore_busy();
    int ndone = 0;
    int lat = 0;
    logic [7:0] got = '0;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (k == 3) begin a = 8'h01; b = 8'h01; cin = 1'b0; end
      if (done) begin ndone++; got = sum; lat = k; end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
    checks++; if (got !== 8'h97) begin errors++; $display("FAIL ignore_sum got %h exp 97", got); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL ignore_latency got %0d exp 9", lat); end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    int bad_hold = 0;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (sum !== 8'h97 || cout !== 1'b0) begin errors++; $display("FAIL b2b_first got %b_%h exp 0_97", cout, sum); end
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (!done && sum !== 8'h97) bad_hold++;
    end while (!done && lat < 40);
    checks++; if (bad_hold !== 0) begin errors++; $display("FAIL b2b_hold got %0d changes exp 0", bad_hold); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency got %0d exp 9", lat); end
    checks++; if (sum !== 8'h30 || cout !== 1'b0) begin errors++; $display("FAIL b2b_second got %b_%h exp 0_30", cout, sum); end
  endtask

  task automatic test_abort();
    int ndone = 0;
    int lat;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (sum !== 8'h00 || cout !== 1'b0) begin errors++; $display("FAIL abort_out got %b_%h exp 0_00", cout, sum); end
    repeat (15) begin @(negedge clk); if (done) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", ndone); end
    do_add(8'h12, 8'h34, 1'b1, lat);
    checks++; if (sum !== 8'h47 || cout !== 1'b0) begin errors++; $display("FAIL abort_next got %b_%h exp 0_47", cout, sum); end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] x, y;
    logic c;
    logic [8:0] exp_r;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      exp_r = model(x, y, c);
      do_add(x, y, c, lat);
      checks++;
      if (lat !== 9 || {cout, sum} !== exp_r) begin
        errors++;
        $display("FAIL random_%0d %h+%h+%b got %b_%h lat %0d exp %b_%h lat 9", i, x, y, c, cout, sum, lat, exp_r[8], exp_r[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_carry();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
